wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  N-master to 1-slave pipelined Wishbone B4 arbiter, successor to the single-cache memory top.
//  Lets several masters share one wb_mem: I-cache, D-cache, debug/DMA.
//  Round-robin grant per bus cycle (CYC); tracks outstanding strobes, caps them, and
//  errors a granted master whose slave stops acknowledging (timeout).
// PARAMETERS
//  NPORTS          2    number of masters (>=2); port 0 = lowest index
//  AW              12   word address width, same as wb_mem
//  MAX_OUTSTANDING 4    max accepted-but-unacked strobes before owner is stalled
//  TIMEOUT         64   cycles with outstanding>0 and no ack before err is forced (>=2)
// PORTS
//  cpu_clock_i     in   1          clock, all logic rising-edge
//  cpu_reset_i     in   1          synchronous reset, active high
//  wb_m_cyc_i      in   NPORTS     per-master CYC
//  wb_m_stb_i      in   NPORTS     per-master STB
//  wb_m_we_i       in   NPORTS     per-master WE
//  wb_m_adr_i      in   NPORTS*AW  per-master address, port p at [p*AW +: AW]
//  wb_m_dat_i      in   NPORTS*32  per-master write data
//  wb_m_sel_i      in   NPORTS*4   per-master byte selects
//  wb_m_stall_o    out  NPORTS     per-master STALL
//  wb_m_ack_o      out  NPORTS     per-master ACK
//  wb_m_err_o      out  NPORTS     per-master ERR
//  wb_m_dat_o      out  32         read data, broadcast (qualify with own ack)
//  wb_s_cyc_o/stb_o/we_o out 1; wb_s_adr_o out AW; wb_s_dat_o out 32; wb_s_sel_o out 4
//  wb_s_stall_i/ack_i/err_i in 1; wb_s_dat_i in 32   slave (wb_mem) side
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, last=NPORTS-1, outstanding=0, timer=0; all wb_m_stall_o=1,
//   ack/err=0; wb_s_cyc_o=stb_o=we_o=0, adr/dat/sel=0.
//  FSM IDLE: stall all masters, slave cyc=0. If any wb_m_cyc_i: owner <= first set bit
//   searching (last+1) mod NPORTS upward with wrap; last <= owner; -> BUSY next edge.
//   Min 1 cycle arbitration latency; none requesting -> stay IDLE.
//  FSM BUSY: slave cyc/stb/we/adr/dat/sel combinationally = owner's inputs (cyc gated by owner cyc).
//   Owner stall = wb_s_stall_i | (outstanding==MAX_OUTSTANDING); when the cap forces stall,
//   slave stb_o is gated to 0. Non-owners: stall=1, ack=0, err=0.
//   Owner ack/err = wb_s_ack_i/err_i; wb_m_dat_o = wb_s_dat_i always.
//  outstanding: +1 on accepted strobe (stb_o & ~wb_s_stall_i), -1 on ack or err; both same cycle
//   -> unchanged. Never exceeds MAX_OUTSTANDING, never underflows (stray ack with 0 ignored).
//  Timer: counts while outstanding>0 and no ack/err; cleared on ack/err or outstanding==0.
//   Reaching TIMEOUT-1: owner err_o=1 for one cycle, outstanding<=0, state -> DRAIN.
//  FSM DRAIN: slave cyc=0 (aborts slave), owner stalled; late slave acks dropped.
//   -> IDLE when owner cyc low.
//  BUSY -> IDLE when owner cyc low: outstanding<=0 next edge (Wishbone abort), slave cyc drops same cycle.
//  Back-to-back: release and new grant are never in the same cycle; >=1 cycle slave cyc=0 between owners.
//  A master dropping cyc while not owner has no effect. Reset mid-transfer: all state to reset values
//   next edge; in-flight acks after reset are ignored.
//  NPORTS not a power of two: wrap computed mod NPORTS, no phantom ports.
// TESTING
//  Single master p0 read adr 0x010 -> 1 IDLE cycle, then slave cyc/stb, ack to p0 only, data matches.
//  p0,p1 request same cycle after reset (last=1) -> p0 granted; release; both again -> p1 granted.
//  NPORTS=3, p2 owns 10 back-to-back strobes, slave never stalls, acks lag 6 -> stall after 4 pending.
//  Slave withholds ack, TIMEOUT=64 -> owner err_o pulse at 64th wait cycle, DRAIN, IDLE after cyc low.
//  cpu_reset_i asserted with 3 outstanding -> next edge all outputs at reset values, later acks ignored.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of per-master and slave-side Wishbone B4 pipelined signals for wb_rr_arbiter.
// The arbiter uses the slave modport; requesters and the memory model use the master modport.
interface wb_rr_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 12
);
  logic [NPORTS-1:0]    wb_m_cyc_i;
  logic [NPORTS-1:0]    wb_m_stb_i;
  logic [NPORTS-1:0]    wb_m_we_i;
  logic [NPORTS*AW-1:0] wb_m_adr_i;
  logic [NPORTS*32-1:0] wb_m_dat_i;
  logic [NPORTS*4-1:0]  wb_m_sel_i;
  logic [NPORTS-1:0]    wb_m_stall_o;
  logic [NPORTS-1:0]    wb_m_ack_o;
  logic [NPORTS-1:0]    wb_m_err_o;
  logic [31:0]          wb_m_dat_o;

  logic                 wb_s_cyc_o;
  logic                 wb_s_stb_o;
  logic                 wb_s_we_o;
  logic [AW-1:0]        wb_s_adr_o;
  logic [31:0]          wb_s_dat_o;
  logic [3:0]           wb_s_sel_o;
  logic                 wb_s_stall_i;
  logic                 wb_s_ack_i;
  logic                 wb_s_err_i;
  logic [31:0]          wb_s_dat_i;

  modport slave (
    input  wb_m_cyc_i, wb_m_stb_i, wb_m_we_i, wb_m_adr_i, wb_m_dat_i, wb_m_sel_i,
    output wb_m_stall_o, wb_m_ack_o, wb_m_err_o, wb_m_dat_o,
    output wb_s_cyc_o, wb_s_stb_o, wb_s_we_o, wb_s_adr_o, wb_s_dat_o, wb_s_sel_o,
    input  wb_s_stall_i, wb_s_ack_i, wb_s_err_i, wb_s_dat_i
  );

  modport master (
    output wb_m_cyc_i, wb_m_stb_i, wb_m_we_i, wb_m_adr_i, wb_m_dat_i, wb_m_sel_i,
    input  wb_m_stall_o, wb_m_ack_o, wb_m_err_o, wb_m_dat_o,
    input  wb_s_cyc_o, wb_s_stb_o, wb_s_we_o, wb_s_adr_o, wb_s_dat_o, wb_s_sel_o,
    output wb_s_stall_i, wb_s_ack_i, wb_s_err_i, wb_s_dat_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone B4 arbiter: round-robin grant per CYC,
// outstanding-strobe cap, and a no-ack timeout that errors the owner and aborts the slave.
module wb_rr_arbiter #(
  parameter int NPORTS          = 2,
  parameter int AW              = 12,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic           cpu_clock_i,
  input  logic           cpu_reset_i,
  wb_rr_arbiter_if.slave wb_io
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] LAST_RESET  = PW'(NPORTS - 1);
  localparam logic [OW-1:0] MAX_OUT     = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] last_q;
  logic [OW-1:0] outstanding_q;
  logic [TW-1:0] timer_q;

  logic [PW-1:0] owner_d;
  logic [OW-1:0] outstanding_d;
  logic [TW-1:0] timer_d;
  logic [PW-1:0] cand;
  logic          grantValid;

  logic          ownerCyc;
  logic          ownerStb;
  logic          ownerWe;
  logic [AW-1:0] ownerAdr;
  logic [31:0]   ownerDat;
  logic [3:0]    ownerSel;

  logic          busy;
  logic          capHit;
  logic          slaveDone;
  logic          timeoutHit;
  logic          slaveStb;
  logic          accepted;
  logic          retire;

  // Wrap is done modulo NPORTS so non-power-of-two port counts never select a phantom port.
  function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NPORTS) sum = sum - NPORTS;
    return PW'(sum);
  endfunction

  always_comb begin
    owner_d    = owner_q;
    grantValid = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = wrapIdx(last_q, i);
      if (!grantValid && wb_io.wb_m_cyc_i[cand]) begin
        grantValid = 1'b1;
        owner_d    = cand;
      end
    end
  end

  always_comb begin
    ownerCyc = wb_io.wb_m_cyc_i[owner_q];
    ownerStb = wb_io.wb_m_stb_i[owner_q];
    ownerWe  = wb_io.wb_m_we_i[owner_q];
    ownerAdr = wb_io.wb_m_adr_i[owner_q*AW +: AW];
    ownerDat = wb_io.wb_m_dat_i[owner_q*32 +: 32];
    ownerSel = wb_io.wb_m_sel_i[owner_q*4 +: 4];
  end

  // The timeout cycle also withholds the strobe, since the transfer is about to be aborted.
  always_comb begin
    busy       = (state_q == BUSY);
    capHit     = (outstanding_q == MAX_OUT);
    slaveDone  = wb_io.wb_s_ack_i | wb_io.wb_s_err_i;
    timeoutHit = busy && ownerCyc && (outstanding_q != '0) && !slaveDone &&
                 (timer_q == TIMER_LIMIT);
    slaveStb   = busy && ownerCyc && ownerStb && !capHit && !timeoutHit;
    accepted   = slaveStb && !wb_io.wb_s_stall_i;
    retire     = slaveDone && (outstanding_q != '0);

    outstanding_d = outstanding_q;
    if (accepted && !retire) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accepted && retire) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    timer_d = '0;
    if ((outstanding_q != '0) && !slaveDone) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    wb_io.wb_m_stall_o = '1;
    wb_io.wb_m_ack_o   = '0;
    wb_io.wb_m_err_o   = '0;
    wb_io.wb_m_dat_o   = wb_io.wb_s_dat_i;
    wb_io.wb_s_cyc_o   = 1'b0;
    wb_io.wb_s_stb_o   = 1'b0;
    wb_io.wb_s_we_o    = 1'b0;
    wb_io.wb_s_adr_o   = '0;
    wb_io.wb_s_dat_o   = '0;
    wb_io.wb_s_sel_o   = '0;
    if (busy) begin
      wb_io.wb_s_cyc_o            = ownerCyc;
      wb_io.wb_s_stb_o            = slaveStb;
      wb_io.wb_s_we_o             = ownerWe;
      wb_io.wb_s_adr_o            = ownerAdr;
      wb_io.wb_s_dat_o            = ownerDat;
      wb_io.wb_s_sel_o            = ownerSel;
      wb_io.wb_m_stall_o[owner_q] = wb_io.wb_s_stall_i | capHit | timeoutHit;
      wb_io.wb_m_ack_o[owner_q]   = wb_io.wb_s_ack_i;
      wb_io.wb_m_err_o[owner_q]   = wb_io.wb_s_err_i | timeoutHit;
    end
  end

  // Release always passes through IDLE, so two owners are separated by a cycle with slave cyc low.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= LAST_RESET;
      outstanding_q <= '0;
      timer_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          outstanding_q <= '0;
          timer_q       <= '0;
          if (grantValid) begin
            owner_q <= owner_d;
            last_q  <= owner_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!ownerCyc) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            timer_q       <= '0;
          end else if (timeoutHit) begin
            state_q       <= DRAIN;
            outstanding_q <= '0;
            timer_q       <= '0;
          end else begin
            outstanding_q <= outstanding_d;
            timer_q       <= timer_d;
          end
        end
        DRAIN: begin
          outstanding_q <= '0;
          timer_q       <= '0;
          if (!ownerCyc) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
